fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DATA_W, default 16: instruction, PC and memory data width in bits.
REQ-002 Parameter QDEPTH, default 4: fetch-queue entries, power of two, 2 to 16.
REQ-003 Parameter RESET_PC, default 0: PC loaded on reset.
REQ-004 Parameter HLT_OPC, default 4'hF: opcode in inst[DATA_W-1:DATA_W-4] that halts fetch.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 redirect_valid  input  1  taken branch from a later stage; flush and refetch.
REQ-008 redirect_pc  input  DATA_W  redirect target.
REQ-009 imem_en  output  1  fetch request this cycle.
REQ-010 imem_addr  output  DATA_W  fetch address, equal to the PC register.
REQ-011 imem_data  input  DATA_W  instruction, valid one cycle after its request.
REQ-012 inst_valid  output  1  queue head valid.
REQ-013 inst_ready  input  1  decode accepts head; a transfer occurs when inst_valid and inst_ready are both high.
REQ-014 inst  output  DATA_W  head instruction.
REQ-015 inst_pc  output  DATA_W  address of the head instruction.
REQ-016 halted  output  1  an HLT was fetched and fetch is stopped.

Function
REQ-017 imem_en is high when all of the following hold:
- rst is low;
- redirect_valid is low;
- halted is low;
- no HLT response arrives this cycle;
- queue count plus in-flight requests is less than QDEPTH.
REQ-018 On each cycle with imem_en high, the PC register advances to PC+2, wrapping modulo 2^DATA_W.
REQ-019 The response to a request arrives in the next cycle and is enqueued with its address at that cycle's edge; inst_valid is high no earlier than 2 cycles after the request.
REQ-020 If the queue is not stalled, fetch issues one request every cycle and the queue delivers one instruction per cycle.
REQ-021 The queue is FIFO. Enqueue and dequeue in the same cycle leaves the count unchanged. A full queue never overflows, because of the credit rule in REQ-017.
REQ-022 When an enqueued response has opcode HLT_OPC:
- the HLT is enqueued;
- halted is set at that edge;
- the PC holds the address of the HLT plus 2;
- no further requests are issued.
REQ-023 A cycle with redirect_valid high causes all of the following at the edge:
- the queue is flushed;
- any in-flight response is discarded;
- the PC is loaded with redirect_pc;
- halted is cleared;
- imem_en is low in that cycle.
REQ-024 The first request after a redirect issues redirect_pc in the following cycle.
REQ-025 When redirect_valid and an HLT response occur in the same cycle, the redirect wins: the HLT is discarded and halted stays 0.
REQ-026 When redirect_valid and a dequeue occur in the same cycle, the dequeue completes and the flush applies to the remaining entries.
REQ-027 A redirect while halted resumes fetch at redirect_pc.

Reset
REQ-028 While rst is high:
- PC = RESET_PC;
- queue empty, inst_valid = 0;
- in-flight flag cleared;
- halted = 0;
- imem_en = 0.
REQ-029 Assertion of rst mid-operation discards all queued and in-flight instructions at that edge.
REQ-030 The first request, to RESET_PC, issues in the first cycle after rst falls.

Configuration
REQ-031 With FETCH_STALL_CNT_EN defined, the block adds output stall_cycles (16 bits). stall_cycles:
- counts cycles where inst_valid is high and inst_ready is low;
- saturates at 16'hFFFF;
- resets to 0 on rst only.
REQ-032 Without FETCH_STALL_CNT_EN, the stall_cycles port and its counter do not exist.

Structure
REQ-033 Package fetch_pkg holds the opcode constants (HLT_OPC, B 4'hC, BR 4'hD) and the queue-entry type (inst, pc).
REQ-034 The queue is sub-module fetch_fifo, parametrised by width and depth, with a synchronous flush input.
REQ-035 The PC register, credit logic and halt/redirect control remain in fetch_unit.

Verification
REQ-036 Streaming: release reset with inst_ready=1 and non-HLT memory -> imem_addr follows 0,2,4,6..., inst_pc=0 at cycle 2, one instruction per cycle.
REQ-037 Backpressure: inst_ready=0 for 10 cycles -> exactly QDEPTH entries are held with imem_en low; on inst_ready=1, the entries drain in order with no loss or duplication.
REQ-038 Halt: word 0x0006=16'hF000 -> halted=1, the last inst_pc is 6, imem_en stays 0, and no instruction from 8 appears.
REQ-039 Redirect: redirect_valid with redirect_pc=0x0040 while 3 entries are queued and 1 is in flight -> inst_valid is 0 next cycle, then inst_pc=0x0040 two cycles later.
REQ-040 HLT response and redirect_pc=0x0020 in the same cycle -> halted stays 0 and fetch proceeds from 0x0020.
REQ-041 With FETCH_STALL_CNT_EN defined, 5 stalled cycles -> stall_cycles=5; rst -> stall_cycles=0.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Opcode constants and queue-entry type shared by the fetch unit.
// Revision    : 1.0
// ============================================================================
package fetch_pkg;

    localparam logic [3:0] c_OPC_HLT = 4'hF;
    localparam logic [3:0] c_OPC_B   = 4'hC;
    localparam logic [3:0] c_OPC_BR  = 4'hD;

    localparam int c_ENTRY_W = 16;

    // Field order matches the {inst, pc} packing written into fetch_fifo.
    typedef struct packed {
        logic [c_ENTRY_W-1:0] inst;
        logic [c_ENTRY_W-1:0] pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Power-of-two FIFO with synchronous reset and flush.
// Revision    : 1.0
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_valid,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_wr;
    logic             w_do_rd;

    assign w_do_rd = i_rd_en && (r_count != '0);
    // A write into a full queue is only accepted when a read frees a slot.
    assign w_do_wr = i_wr_en && ((r_count != (c_AW+1)'(DEPTH)) || w_do_rd);

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_valid   = (r_count != '0);
    assign o_count   = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch with credit-limited queue, HLT stop and
//               redirect flush. Optional stall counter: FETCH_STALL_CNT_EN.
// Revision    : 1.0
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                QDEPTH   = 4,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HLT_OPC  = c_OPC_HLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [DATA_W-1:0] redirect_pc,
    output logic              imem_en,
    output logic [DATA_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [DATA_W-1:0] inst_pc,
    output logic              halted
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);

    localparam int c_CW = $clog2(QDEPTH) + 1;

    logic [DATA_W-1:0]   r_pc;
    logic [DATA_W-1:0]   r_req_pc;
    logic                r_inflight;
    logic                r_halted;
    logic [c_CW-1:0]     w_count;
    logic [c_CW:0]       w_used;
    logic                w_hlt_resp;
    logic                w_enq;
    logic                w_deq;
    logic                w_fetch;
    logic [2*DATA_W-1:0] w_wr_entry;
    logic [2*DATA_W-1:0] w_rd_entry;

    assign w_hlt_resp = r_inflight && (imem_data[DATA_W-1 -: 4] == HLT_OPC);
    // Queued entries plus the outstanding request must leave room for it.
    assign w_used     = {1'b0, w_count} + {{c_CW{1'b0}}, r_inflight};
    assign w_fetch    = !rst && !redirect_valid && !r_halted && !w_hlt_resp
                        && (w_used < (c_CW+1)'(QDEPTH));
    assign w_enq      = r_inflight && !redirect_valid;
    assign w_deq      = inst_valid && inst_ready;
    assign w_wr_entry = {imem_data, r_req_pc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_inflight <= 1'b0;
            r_halted   <= 1'b0;
        end else if (redirect_valid) begin
            r_pc       <= redirect_pc;
            r_inflight <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_inflight <= w_fetch;
            if (w_fetch) begin
                r_pc     <= r_pc + DATA_W'(2);
                r_req_pc <= r_pc;
            end
            if (w_hlt_resp) begin
                r_halted <= 1'b1;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (redirect_valid),
        .i_wr_en   (w_enq),
        .i_wr_data (w_wr_entry),
        .i_rd_en   (w_deq),
        .o_rd_data (w_rd_entry),
        .o_valid   (inst_valid),
        .o_count   (w_count)
    );

    assign imem_en   = w_fetch;
    assign imem_addr = r_pc;
    assign inst      = w_rd_entry[2*DATA_W-1:DATA_W];
    assign inst_pc   = w_rd_entry[DATA_W-1:0];
    assign halted    = r_halted;

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (inst_valid && !inst_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cnt;
`endif

endmodule
`default_nettype wire
